// File: rtl/kalman_mm_pkg.sv
// ---------------------------------------------------------------------------
// kalman_mm_pkg
//   Shared types for the host-side driver of the 12x12 systolic matmul engine.
//   - seq_state_t : job sequencer states (fill, fire, wait, drain)
//   - MM_N, MM_DWIDTH : default matrix dimension and IEEE-754 word width
//   - ROW_W, row_t : one packed matrix row (MM_N words)
// ---------------------------------------------------------------------------
package kalman_mm_pkg;

    localparam int MM_N      = 12;
    localparam int MM_DWIDTH = 64;
    localparam int ROW_W     = MM_N * MM_DWIDTH;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_FIRE  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mm_row_unpack.sv
// ---------------------------------------------------------------------------
// mm_row_unpack
//   Purely combinational slicer between a packed row and an array of words.
//   Word j of a row lives at bits [j*DWIDTH +: DWIDTH].
//   Ports:
//     row_i   : packed row to split (ingress side)
//     words_o : row_i split into N words
//     words_i : N words to join (egress side)
//     row_o   : words_i packed into one row
// ---------------------------------------------------------------------------
module mm_row_unpack
    import kalman_mm_pkg::*;
#(
    parameter int DWIDTH = MM_DWIDTH,
    parameter int N      = MM_N
) (
    input  logic [N*DWIDTH-1:0] row_i,
    output logic [DWIDTH-1:0]   words_o [0:N-1],
    input  logic [DWIDTH-1:0]   words_i [0:N-1],
    output logic [N*DWIDTH-1:0] row_o
);

    for (genvar j = 0; j < N; j++) begin : g_word
        assign words_o[j]                   = row_i[j*DWIDTH +: DWIDTH];
        assign row_o[j*DWIDTH +: DWIDTH]    = words_i[j];
    end

endmodule

// File: rtl/matmul_job_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_job_sequencer
//   Host-side driver for the NxN systolic matmul engine. Collects A then B as
//   row beats on a valid/ready stream, holds them as full matrices for the
//   engine, raises load_en, waits for cal_finish (bounded by TIMEOUT), captures
//   C and streams it back out as row beats.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     in_valid/in_ready    : ingress handshake; in_data is one row
//     cfg_enb              : {enb_7_12,enb_2_6,enb_1}, latched on the first A beat
//     a_row, b_col         : A and B buffers presented to the engine
//     enb_1/enb_2_6/enb_7_12 : latched engine enables
//     load_en              : engine start level, high for the whole wait
//     c_out, cal_finish    : engine result and done pulse
//     out_valid/out_ready  : egress handshake; out_data is C[out_row]
//     out_row, out_last    : egress row index, high on the final row
//     busy                 : a job is in progress
//     err_timeout          : sticky abort flag, cleared by the next job's first beat
// ---------------------------------------------------------------------------
module matmul_job_sequencer
    import kalman_mm_pkg::*;
#(
    parameter int DWIDTH  = MM_DWIDTH,
    parameter int N       = MM_N,
    parameter int TIMEOUT = 8192
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DWIDTH-1:0]    in_data,
    input  logic [2:0]             cfg_enb,
    output logic [DWIDTH-1:0]      a_row [0:N-1][0:N-1],
    output logic [DWIDTH-1:0]      b_col [0:N-1][0:N-1],
    output logic                   enb_1,
    output logic                   enb_2_6,
    output logic                   enb_7_12,
    output logic                   load_en,
    input  logic [DWIDTH-1:0]      c_out [0:N-1][0:N-1],
    input  logic                   cal_finish,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*DWIDTH-1:0]    out_data,
    output logic [$clog2(N)-1:0]   out_row,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int BEAT_W = $clog2(2 * N);
    localparam int ROW_IW = $clog2(N);
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * N - 1);
    localparam logic [BEAT_W-1:0] B_BASE    = BEAT_W'(N);
    localparam logic [ROW_IW-1:0] LAST_ROW  = ROW_IW'(N - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT - 1);

    // Control state
    seq_state_t          state_q,   state_d;
    logic [BEAT_W-1:0]   beat_q,    beat_d;
    logic [TCNT_W-1:0]   tcnt_q,    tcnt_d;
    logic [ROW_IW-1:0]   out_row_q, out_row_d;
    logic [2:0]          enb_q,     enb_d;
    logic                load_en_q, load_en_d;
    logic                err_q,     err_d;

    // Matrix buffers
    logic [DWIDTH-1:0]   a_q [0:N-1][0:N-1];
    logic [DWIDTH-1:0]   b_q [0:N-1][0:N-1];
    logic [DWIDTH-1:0]   c_q [0:N-1][0:N-1];

    // Row slicing for both directions
    logic [DWIDTH-1:0]   in_words [0:N-1];
    logic [DWIDTH-1:0]   c_sel    [0:N-1];

    logic                in_accept;
    logic                c_capture;
    logic                beat_is_b;
    logic [ROW_IW-1:0]   wr_row;

    mm_row_unpack #(
        .DWIDTH (DWIDTH),
        .N      (N)
    ) u_row_unpack (
        .row_i   (in_data),
        .words_o (in_words),
        .words_i (c_sel),
        .row_o   (out_data)
    );

    assign c_sel = c_q[out_row_q];

    // Beats 0..N-1 fill A, beats N..2N-1 fill B; both use row beat%N.
    assign beat_is_b = (beat_q >= B_BASE);
    assign wr_row    = ROW_IW'(beat_is_b ? (beat_q - B_BASE) : beat_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d   = state_q;
        beat_d    = beat_q;
        tcnt_d    = tcnt_q;
        out_row_d = out_row_q;
        enb_d     = enb_q;
        load_en_d = load_en_q;
        err_d     = err_q;
        in_accept = 1'b0;
        c_capture = 1'b0;

        unique case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    in_accept = 1'b1;
                    if (beat_q == '0) begin
                        // First beat of a job: latch enables, clear a stale abort.
                        enb_d = cfg_enb;
                        err_d = 1'b0;
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_FIRE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            S_FIRE: begin
                load_en_d = 1'b1;
                tcnt_d    = '0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                // A completion in the final allowed cycle still wins over the abort.
                if (cal_finish) begin
                    c_capture = 1'b1;
                    load_en_d = 1'b0;
                    tcnt_d    = '0;
                    out_row_d = '0;
                    state_d   = S_DRAIN;
                end else if (tcnt_q == TCNT_MAX) begin
                    load_en_d = 1'b0;
                    err_d     = 1'b1;
                    tcnt_d    = '0;
                    beat_d    = '0;
                    state_d   = S_FILL;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            S_DRAIN: begin
                // out_row only moves on a handshake, so data holds while stalled.
                if (out_ready) begin
                    if (out_row_q == LAST_ROW) begin
                        out_row_d = '0;
                        beat_d    = '0;
                        state_d   = S_FILL;
                    end else begin
                        out_row_d = out_row_q + 1'b1;
                    end
                end
            end

            default: state_d = S_FILL;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q   <= S_FILL;
            beat_q    <= '0;
            tcnt_q    <= '0;
            out_row_q <= '0;
            enb_q     <= '0;
            load_en_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            tcnt_q    <= tcnt_d;
            out_row_q <= out_row_d;
            enb_q     <= enb_d;
            load_en_q <= load_en_d;
            err_q     <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Matrix buffers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffers are reset on purpose: the engine shares rst_n and
        // must never see a stale matrix from an aborted job.
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int w = 0; w < N; w++) begin
                    a_q[r][w] <= '0;
                    b_q[r][w] <= '0;
                    c_q[r][w] <= '0;
                end
            end
        end else begin
            if (in_accept && !beat_is_b) a_q[wr_row] <= in_words;
            if (in_accept &&  beat_is_b) b_q[wr_row] <= in_words;
            if (c_capture)               c_q         <= c_out;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready    = (state_q == S_FILL);
    assign out_valid   = (state_q == S_DRAIN);
    assign out_row     = out_row_q;
    assign out_last    = out_valid && (out_row_q == LAST_ROW);
    assign busy        = (state_q != S_FILL) || (beat_q != '0);
    assign load_en     = load_en_q;
    assign err_timeout = err_q;
    assign enb_1       = enb_q[0];
    assign enb_2_6     = enb_q[1];
    assign enb_7_12    = enb_q[2];
    assign a_row       = a_q;
    assign b_col       = b_q;

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matmul_job_sequencer
//   Directed bench for matmul_job_sequencer. A table of jobs (config, engine
//   delay, egress ready pattern, A scale, B seed) is run through the main
//   instance against a behavioural engine; hand-written sequences cover the
//   timeout abort (separate instance with TIMEOUT=16) and reset mid-job.
// ---------------------------------------------------------------------------
module tb_matmul_job_sequencer;
    import kalman_mm_pkg::*;

    localparam int N  = 12;
    localparam int DW = 64;

    typedef logic [DW-1:0] word_t;

    typedef struct {
        logic [2:0] cfg;
        int         delay;
        logic [3:0] rdy;
        int         scale;
        int         seed;
        bit         stray;
        logic [2:0] exp_enb;
    } vec_t;

    logic clk;
    logic rst_n;

    // Main instance
    logic       in_valid, in_ready, out_ready, cal_finish;
    row_t       in_data;
    logic [2:0] cfg_enb;
    word_t      a_row [0:N-1][0:N-1];
    word_t      b_col [0:N-1][0:N-1];
    word_t      c_out [0:N-1][0:N-1];
    logic       enb_1, enb_2_6, enb_7_12, load_en;
    logic       out_valid, out_last, busy, err_timeout;
    row_t       out_data;
    logic [3:0] out_row;

    // Timeout instance (engine never answers)
    logic       in_valid_t, in_ready_t;
    word_t      a_row_t [0:N-1][0:N-1];
    word_t      b_col_t [0:N-1][0:N-1];
    logic       enb_1_t, enb_2_6_t, enb_7_12_t, load_en_t;
    logic       out_valid_t, out_last_t, busy_t, err_t;
    row_t       out_data_t;
    logic [3:0] out_row_t;

    matmul_job_sequencer #(.DWIDTH(DW), .N(N), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .cfg_enb(cfg_enb),
        .a_row(a_row), .b_col(b_col),
        .enb_1(enb_1), .enb_2_6(enb_2_6), .enb_7_12(enb_7_12), .load_en(load_en),
        .c_out(c_out), .cal_finish(cal_finish),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .busy(busy), .err_timeout(err_timeout)
    );

    matmul_job_sequencer #(.DWIDTH(DW), .N(N), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_t), .in_ready(in_ready_t), .in_data(in_data), .cfg_enb(cfg_enb),
        .a_row(a_row_t), .b_col(b_col_t),
        .enb_1(enb_1_t), .enb_2_6(enb_2_6_t), .enb_7_12(enb_7_12_t), .load_en(load_en_t),
        .c_out(c_out), .cal_finish(1'b0),
        .out_valid(out_valid_t), .out_ready(1'b1), .out_data(out_data_t),
        .out_row(out_row_t), .out_last(out_last_t), .busy(busy_t), .err_timeout(err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    word_t amat [0:N-1][0:N-1];
    word_t bmat [0:N-1][0:N-1];
    word_t cexp [0:N-1][0:N-1];
    vec_t  vecs [0:3];

    // ------------------------------------------------------------------
    // Engine model and observation of load_en / out_valid timing
    // ------------------------------------------------------------------
    int         eng_delay = 1000;
    bit         stray     = 1'b0;
    int         le_run    = 0;
    int         le_last   = 0;
    int         fin_cyc   = 0;
    int         ov_cyc    = 0;
    bit         le_prev   = 1'b0;
    bit         ov_prev   = 1'b0;
    logic [2:0] enb_wait  = 3'b000;
    bit         enb_changed = 1'b0;
    real        acc;

    always @(negedge clk) begin
        if (load_en) begin
            if (!le_prev) begin
                le_run      = 0;
                enb_wait    = {enb_7_12, enb_2_6, enb_1};
                enb_changed = 1'b0;
            end
            le_run++;
            if ({enb_7_12, enb_2_6, enb_1} != enb_wait) enb_changed = 1'b1;
            if (le_run == eng_delay) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        acc = 0.0;
                        for (int k = 0; k < N; k++)
                            acc = acc + $bitstoreal(a_row[i][k]) * $bitstoreal(b_col[k][j]);
                        c_out[i][j] = $realtobits(acc);
                    end
                end
                cal_finish = 1'b1;
                fin_cyc    = cyc;
            end else begin
                cal_finish = 1'b0;
            end
        end else begin
            if (le_prev) le_last = le_run;
            cal_finish = stray;
        end
        if (out_valid && !ov_prev) ov_cyc = cyc;
        le_prev = load_en;
        ov_prev = out_valid;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic row_t mrow(input bit is_b, input int r);
        row_t x;
        for (int j = 0; j < N; j++) x[j*DW +: DW] = is_b ? bmat[r][j] : amat[r][j];
        return x;
    endfunction

    function automatic row_t crow(input int r);
        row_t x;
        for (int j = 0; j < N; j++) x[j*DW +: DW] = cexp[r][j];
        return x;
    endfunction

    function automatic int first_diff(input row_t a, input row_t b);
        for (int j = 0; j < N; j++) if (a[j*DW +: DW] !== b[j*DW +: DW]) return j;
        return 0;
    endfunction

    // A = scale*I, B[i][j] = seed + 12i + j, so C = scale*B exactly in doubles.
    task automatic prep(input vec_t v);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                amat[i][j] = (i == j) ? $realtobits(real'(v.scale)) : 64'd0;
                bmat[i][j] = $realtobits(real'(v.seed + i * N + j));
                cexp[i][j] = $realtobits(real'(v.scale * (v.seed + i * N + j)));
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input bit sel, input row_t d, input logic [2:0] cfg);
        int guard = 0;
        in_data = d;
        cfg_enb = cfg;
        if (sel) in_valid_t = 1'b1; else in_valid = 1'b1;
        while (!(sel ? in_ready_t : in_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("ingress_wait", 0, 1);
        @(negedge clk);
        in_valid   = 1'b0;
        in_valid_t = 1'b0;
    endtask

    task automatic send_job(input bit sel, input logic [2:0] cfg);
        for (int b = 0; b < 2 * N; b++)
            send_beat(sel, mrow(b >= N, b % N), (b == 0) ? cfg : ~cfg);
    endtask

    task automatic drain(input logic [3:0] pat);
        int   got   = 0;
        int   guard = 0;
        int   k     = 0;
        int   fd;
        bit   held  = 1'b0;
        row_t hold_d;
        logic [3:0] hold_r;
        while (got < N && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (held) begin
                check("hold_row", out_row, hold_r);
                fd = first_diff(out_data, hold_d);
                check("hold_data", out_data[fd*DW +: DW], hold_d[fd*DW +: DW]);
                held = 1'b0;
            end
            out_ready = pat[k % 4];
            k++;
            if (out_valid) begin
                if (out_ready) begin
                    check("drain_row", out_row, got);
                    fd = first_diff(out_data, crow(got));
                    check("drain_data", out_data[fd*DW +: DW], cexp[got][fd]);
                    check("drain_last", out_last, (got == N - 1));
                    got++;
                end else begin
                    held   = 1'b1;
                    hold_r = out_row;
                    hold_d = out_data;
                end
            end
        end
        if (guard >= 2000) check("drain_rows", got, N);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_job(input int idx);
        vec_t v;
        v = vecs[idx];
        prep(v);
        eng_delay = v.delay;
        for (int b = 0; b < 2 * N; b++) begin
            send_beat(1'b0, mrow(b >= N, b % N), (b == 0) ? v.cfg : ~v.cfg);
            if (b == 0) begin
                check("busy_after_first", busy, 1);
                check("enb_latched", {enb_7_12, enb_2_6, enb_1}, v.exp_enb);
            end
            if (b == 3 && v.stray) begin
                // Stray cal_finish while filling must be ignored.
                #2 stray = 1'b1;
                @(negedge clk);
                #2 stray = 1'b0;
                @(negedge clk);
                check("stray_in_ready", in_ready, 1);
                check("stray_out_valid", out_valid, 0);
                check("stray_load_en", load_en, 0);
            end
        end
        // In S_FIRE now: ingress closed, load_en rises on the next edge.
        check("fire_in_ready", in_ready, 0);
        check("fire_load_en", load_en, 0);
        @(negedge clk);
        check("wait_load_en", load_en, 1);
        drain(v.rdy);
        check("load_en_cycles", le_last, v.delay);
        check("finish_to_valid", ov_cyc - fin_cyc, 1);
        check("enb_held", enb_changed, 0);
        check("enb_during_wait", enb_wait, v.exp_enb);
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 1);
        check("rst_load_en", load_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_row", out_row, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_timeout, 0);
        check("rst_enb", {enb_7_12, enb_2_6, enb_1}, 3'b000);
        check("rst_a00", a_row[0][0], 0);
        check("rst_b_last", b_col[N-1][N-1], 0);
        check("rst_out_data", out_data[DW-1:0], 0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int hi;
        int g;
        bit seen;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_valid_t = 1'b0;
        in_data    = '0;
        cfg_enb    = 3'b000;
        out_ready  = 1'b0;

        vecs[0] = '{cfg: 3'b111, delay: 5,  rdy: 4'b1111, scale: 1, seed: 0,   stray: 1'b0, exp_enb: 3'b111};
        vecs[1] = '{cfg: 3'b001, delay: 37, rdy: 4'b1111, scale: 2, seed: 100, stray: 1'b0, exp_enb: 3'b001};
        vecs[2] = '{cfg: 3'b010, delay: 1,  rdy: 4'b1001, scale: 1, seed: 7,   stray: 1'b1, exp_enb: 3'b010};
        vecs[3] = '{cfg: 3'b100, delay: 9,  rdy: 4'b0110, scale: 3, seed: 50,  stray: 1'b0, exp_enb: 3'b100};

        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_job(i);

        // Timeout abort on the TIMEOUT=16 instance.
        prep(vecs[0]);
        send_job(1'b1, 3'b111);
        hi   = 0;
        g    = 0;
        seen = 1'b0;
        while (g < 200) begin
            @(negedge clk);
            g++;
            if (load_en_t) begin
                seen = 1'b1;
                hi++;
            end else if (seen) begin
                break;
            end
        end
        check("to_load_en_cycles", hi, 16);
        check("to_err", err_t, 1);
        check("to_in_ready", in_ready_t, 1);
        check("to_out_valid", out_valid_t, 0);
        check("to_busy", busy_t, 0);
        send_beat(1'b1, mrow(1'b0, 0), 3'b111);
        check("to_err_cleared", err_t, 0);

        // Reset while the main instance waits on the engine.
        prep(vecs[1]);
        eng_delay = 1000;
        send_job(1'b0, 3'b011);
        repeat (3) @(negedge clk);
        check("pre_rst_load_en", load_en, 1);
        check("pre_rst_enb", {enb_7_12, enb_2_6, enb_1}, 3'b011);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
